aes_output_buffer: RTL

AES_OUTPUT_BUFFER -- requirements
Module: aes_output_buffer

---
 rtl/aes_pkg.sv | 29 ++
 rtl/aes_output_buffer_if.sv | 25 ++
 rtl/aes_block_fifo.sv | 61 ++++++
 rtl/aes_output_buffer.sv | 118 +++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared types and constants for the AES result output path.
package aes_pkg;

  localparam int AES_WORD_W  = 32;
  localparam int AES_BLOCK_W = 128;
  localparam int AES_WORDS   = 4;

  typedef logic [AES_WORD_W-1:0]  aes_word_t;
  typedef logic [AES_BLOCK_W-1:0] aes_block_t;

  // Serializer states: IDLE drives nothing, SEND presents a valid word.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } ser_state_e;

  // Select one 32-bit word of a block, word 0 being the least significant.
  function automatic aes_word_t word_of(input aes_block_t blk, input logic [1:0] idx);
    aes_word_t w;
    case (idx)
      2'd0:    w = blk[31:0];
      2'd1:    w = blk[63:32];
      2'd2:    w = blk[95:64];
      default: w = blk[127:96];
    endcase
    return w;
  endfunction

endpackage

// File: rtl/aes_output_buffer_if.sv
// Core-to-consumer bundle: result pulse in, word stream and status out.
interface aes_output_buffer_if;
  import aes_pkg::*;

  logic       done_i;
  aes_block_t text_i;
  logic       ready_i;
  aes_word_t  text_o;
  logic       valid_o;
  logic       last_o;
  logic       full_o;
  logic       ovf_o;

  // Environment side: AES core plus downstream consumer.
  modport master (
    output done_i, text_i, ready_i,
    input  text_o, valid_o, last_o, full_o, ovf_o
  );

  // Buffer side.
  modport slave (
    input  done_i, text_i, ready_i,
    output text_o, valid_o, last_o, full_o, ovf_o
  );
endinterface

// File: rtl/aes_block_fifo.sv
// Small circular FIFO of 128-bit result blocks with head and next-head peek.
module aes_block_fifo
  import aes_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  aes_block_t din,
  output aes_block_t head,
  output aes_block_t next_head,
  output logic [2:0] count,
  output logic       full,
  output logic       empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [2:0]       count_n;
  aes_block_t       mem [DEPTH];

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Occupancy after this cycle's push/pop; push and pop together cancel.
  always_comb begin
    count_n = count + {2'b00, push} - {2'b00, pop};
  end

  // Pointer, occupancy and registered full flag.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      count <= count_n;
      full  <= (count_n == 3'(DEPTH));
    end
  end

  // Block storage.
  // NOTE: the data array has no reset; count marks which slots are meaningful, so clearing it buys nothing.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  assign head      = mem[rd_ptr];
  assign next_head = mem[ptr_inc(rd_ptr)];
  assign empty     = (count == 3'd0);

endmodule

// File: rtl/aes_output_buffer.sv
// Buffers AES result blocks and streams them out as four 32-bit words with valid/ready.
module aes_output_buffer
  import aes_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input logic                clk,
  input logic                rst,
  aes_output_buffer_if.slave bus
);

  ser_state_e state, state_n;
  logic [1:0] word_cnt, word_cnt_n;
  aes_word_t  text_q, text_n;
  logic       last_q, last_n;
  logic       ovf_q;

  logic       xfer;
  logic       pop;
  logic       push;
  aes_block_t head;
  aes_block_t next_head;
  logic [2:0] count;
  logic       full;
  logic       empty;

  // A word-3 transfer frees a slot in the same cycle, so a full FIFO can still accept.
  assign xfer = (state == ST_SEND) && bus.ready_i;
  assign pop  = xfer && (word_cnt == 2'd3);
  assign push = bus.done_i && (!full || pop);

  aes_block_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .pop       (pop),
    .din       (bus.text_i),
    .head      (head),
    .next_head (next_head),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  // Next state and next registered outputs; the incoming block bypasses the FIFO when it becomes head.
  // NOTE: every variable gets a default before the case so no path can infer a latch.
  always_comb begin
    state_n    = state;
    word_cnt_n = word_cnt;
    text_n     = text_q;
    last_n     = last_q;
    case (state)
      ST_IDLE: begin
        if (!empty) begin
          state_n    = ST_SEND;
          word_cnt_n = 2'd0;
          text_n     = word_of(head, 2'd0);
          last_n     = 1'b0;
        end else if (push) begin
          state_n    = ST_SEND;
          word_cnt_n = 2'd0;
          text_n     = word_of(bus.text_i, 2'd0);
          last_n     = 1'b0;
        end
      end
      ST_SEND: begin
        if (xfer) begin
          if (word_cnt != 2'd3) begin
            word_cnt_n = word_cnt + 2'd1;
            text_n     = word_of(head, word_cnt + 2'd1);
            last_n     = (word_cnt == 2'd2);
          end else begin
            word_cnt_n = 2'd0;
            last_n     = 1'b0;
            if (count > 3'd1) begin
              text_n = word_of(next_head, 2'd0);
            end else if (push) begin
              text_n = word_of(bus.text_i, 2'd0);
            end else begin
              state_n = ST_IDLE;
              text_n  = '0;
            end
          end
        end
      end
      default: begin
        state_n    = ST_IDLE;
        word_cnt_n = 2'd0;
        text_n     = '0;
        last_n     = 1'b0;
      end
    endcase
  end

  // Serializer state and output registers; overflow is sticky until reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      word_cnt <= 2'd0;
      text_q   <= '0;
      last_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state    <= state_n;
      word_cnt <= word_cnt_n;
      text_q   <= text_n;
      last_q   <= last_n;
      ovf_q    <= ovf_q | (bus.done_i && full && !pop);
    end
  end

  assign bus.text_o  = text_q;
  assign bus.valid_o = (state == ST_SEND);
  assign bus.last_o  = last_q;
  assign bus.full_o  = full;
  assign bus.ovf_o   = ovf_q;

endmodule
